// File: rtl/fpu_pkg.sv
// Shared opcodes, scheduler state encoding and response-flag bit positions
// for the FPU command scheduler.
package fpu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_LOAD = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LD_EN    = 3'd1,
        ST_LD_PULSE = 3'd2,
        ST_ISSUE    = 3'd3,
        ST_WAIT     = 3'd4,
        ST_RESP     = 3'd5
    } state_t;

    localparam int unsigned FLAG_W      = 9;
    localparam int unsigned FL_LESS     = 0;
    localparam int unsigned FL_GREAT    = 1;
    localparam int unsigned FL_EQ       = 2;
    localparam int unsigned FL_INEXACT  = 3;
    localparam int unsigned FL_DIV_ZERO = 4;
    localparam int unsigned FL_INV      = 5;
    localparam int unsigned FL_UN       = 6;
    localparam int unsigned FL_OV       = 7;
    localparam int unsigned FL_TIMEOUT  = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant from the request
// vector, favouring the requester held in the pointer register.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    input  logic       i_owner,
    output logic [1:0] o_gnt_c,
    output logic       o_sel_c
);

    logic r_ptr;

    always_comb begin
        o_gnt_c = 2'b00;
        o_sel_c = r_ptr;
        if (i_req[r_ptr]) begin
            o_gnt_c[r_ptr] = 1'b1;
        end else if (i_req[~r_ptr]) begin
            o_gnt_c[~r_ptr] = 1'b1;
            o_sel_c         = ~r_ptr;
        end
    end

    // After a completion the other requester gets priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (i_upd) begin
            r_ptr <= ~i_owner;
        end
    end

endmodule

// File: rtl/fpu_cmd_sched.sv
// Round-robin command scheduler in front of the FPU core: grants one of two
// requesters, sequences the command onto the FPU pins and returns the result.
module fpu_cmd_sched
    import fpu_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   test_mode,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0][2:0]        req_op,
    input  logic [1:0][ADDR_W-1:0] req_a1,
    input  logic [1:0][ADDR_W-1:0] req_a2,
    input  logic [1:0][ADDR_W-1:0] req_a3,
    input  logic [1:0][WIDTH-1:0]  req_data,
    output logic [1:0]             resp_valid,
    output logic [WIDTH-1:0]       resp_data,
    output logic [FLAG_W-1:0]      resp_flags,
    output logic                   busy,
    output logic                   fpu_enable,
    output logic                   fpu_ld,
    output logic [2:0]             fpu_opcode,
    output logic [ADDR_W-1:0]      fpu_addr1,
    output logic [ADDR_W-1:0]      fpu_addr2,
    output logic [ADDR_W-1:0]      fpu_addr3,
    output logic [WIDTH-1:0]       fpu_inp,
    input  logic                   fpu_done,
    input  logic [WIDTH-1:0]       fpu_out,
    input  logic [7:0]             fpu_flags
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                r_owner;
    logic [2:0]          r_op;
    logic [ADDR_W-1:0]   r_a1;
    logic [ADDR_W-1:0]   r_a2;
    logic [ADDR_W-1:0]   r_a3;
    logic [WIDTH-1:0]    r_inp;
    logic                r_busy;
    logic                r_fpu_enable;
    logic                r_fpu_ld;
    logic [1:0]          r_resp_valid;
    logic [WIDTH-1:0]    r_resp_data;
    logic [FLAG_W-1:0]   r_resp_flags;

    logic [1:0]          w_gnt;
    logic                w_sel;
    logic                w_grant;
    logic                w_ptr_upd;
    logic                w_cap;
    logic [WIDTH-1:0]    w_cap_data;
    logic [FLAG_W-1:0]   w_cap_flags;
    logic                w_enable;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_req   (req_valid),
        .i_upd   (w_ptr_upd),
        .i_owner (r_owner),
        .o_gnt_c (w_gnt),
        .o_sel_c (w_sel)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_grant     = 1'b0;
        w_ptr_upd   = 1'b0;
        w_cap       = 1'b0;
        w_cap_data  = '0;
        w_cap_flags = '0;
        case (r_state)
            ST_IDLE: begin
                if (!test_mode && (|w_gnt)) begin
                    w_grant     = 1'b1;
                    w_state_nxt = (req_op[w_sel] == OP_LOAD) ? ST_LD_EN : ST_ISSUE;
                end
            end
            ST_LD_EN: begin
                w_state_nxt = ST_LD_PULSE;
            end
            ST_LD_PULSE: begin
                w_cap       = 1'b1;
                w_state_nxt = ST_RESP;
            end
            ST_ISSUE: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                // done takes priority over an expiring counter
                if (fpu_done) begin
                    w_cap       = 1'b1;
                    w_cap_data  = fpu_out;
                    w_cap_flags = {1'b0, fpu_flags};
                    w_state_nxt = ST_RESP;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_cap                   = 1'b1;
                    w_cap_flags[FL_TIMEOUT] = 1'b1;
                    w_state_nxt             = ST_RESP;
                end
            end
            ST_RESP: begin
                w_ptr_upd   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_enable = (w_state_nxt == ST_LD_EN) || (w_state_nxt == ST_LD_PULSE) ||
                   (w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_WAIT);
    end

    // Output stage is loaded from the next state so each pin lines up with its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_owner      <= 1'b0;
            r_op         <= '0;
            r_a1         <= '0;
            r_a2         <= '0;
            r_a3         <= '0;
            r_inp        <= '0;
            r_busy       <= 1'b0;
            r_fpu_enable <= 1'b0;
            r_fpu_ld     <= 1'b0;
            r_resp_valid <= 2'b00;
            r_resp_data  <= '0;
            r_resp_flags <= '0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_fpu_enable <= w_enable;
            r_fpu_ld     <= (w_state_nxt == ST_LD_PULSE);
            r_resp_valid <= (w_state_nxt == ST_RESP) ? (2'b01 << r_owner) : 2'b00;
            if (w_grant) begin
                r_owner <= w_sel;
                r_op    <= req_op[w_sel];
                r_a1    <= req_a1[w_sel];
                r_a2    <= req_a2[w_sel];
                r_a3    <= req_a3[w_sel];
                r_inp   <= req_data[w_sel];
            end
            if (w_cap) begin
                r_resp_data  <= w_cap_data;
                r_resp_flags <= w_cap_flags;
            end
        end
    end

    // Accept is a same-cycle handshake, masked while reset is asserted.
    assign req_ready  = (w_grant && !rst) ? w_gnt : 2'b00;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_flags = r_resp_flags;
    assign busy       = r_busy;
    assign fpu_enable = r_fpu_enable;
    assign fpu_ld     = r_fpu_ld;
    assign fpu_opcode = r_op;
    assign fpu_addr1  = r_a1;
    assign fpu_addr2  = r_a2;
    assign fpu_addr3  = r_a3;
    assign fpu_inp    = r_inp;

endmodule

// File: tb/tb_fpu_cmd_sched.sv
// Directed bench for fpu_cmd_sched with a response scoreboard and a
// hand-driven FPU done/result model.
module tb_fpu_cmd_sched;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned TMO    = 8;

    logic                   clk;
    logic                   rst;
    logic                   test_mode;
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0][2:0]        req_op;
    logic [1:0][ADDR_W-1:0] req_a1;
    logic [1:0][ADDR_W-1:0] req_a2;
    logic [1:0][ADDR_W-1:0] req_a3;
    logic [1:0][WIDTH-1:0]  req_data;
    logic [1:0]             resp_valid;
    logic [WIDTH-1:0]       resp_data;
    logic [8:0]             resp_flags;
    logic                   busy;
    logic                   fpu_enable;
    logic                   fpu_ld;
    logic [2:0]             fpu_opcode;
    logic [ADDR_W-1:0]      fpu_addr1;
    logic [ADDR_W-1:0]      fpu_addr2;
    logic [ADDR_W-1:0]      fpu_addr3;
    logic [WIDTH-1:0]       fpu_inp;
    logic                   fpu_done;
    logic [WIDTH-1:0]       fpu_out;
    logic [7:0]             fpu_flags;

    fpu_cmd_sched #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .test_mode  (test_mode),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a1     (req_a1),
        .req_a2     (req_a2),
        .req_a3     (req_a3),
        .req_data   (req_data),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_flags (resp_flags),
        .busy       (busy),
        .fpu_enable (fpu_enable),
        .fpu_ld     (fpu_ld),
        .fpu_opcode (fpu_opcode),
        .fpu_addr1  (fpu_addr1),
        .fpu_addr2  (fpu_addr2),
        .fpu_addr3  (fpu_addr3),
        .fpu_inp    (fpu_inp),
        .fpu_done   (fpu_done),
        .fpu_out    (fpu_out),
        .fpu_flags  (fpu_flags)
    );

    typedef struct {
        logic [1:0]  onehot;
        logic [31:0] data;
        logic [8:0]  flags;
        bit          chk_data;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   failures  = 0;
    int   resp_seen = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] oh, input logic [31:0] d, input logic [8:0] f, input bit cd);
        exp_t e;
        e.onehot   = oh;
        e.data     = d;
        e.flags    = f;
        e.chk_data = cd;
        sb.push_back(e);
    endtask

    task automatic check_resp();
        exp_t e;
        if (resp_valid !== 2'b00) begin
            resp_seen++;
            if (sb.size() == 0) begin
                chk("resp_unexpected", 64'(resp_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_owner", 64'(resp_valid), 64'(e.onehot));
                if (e.chk_data) chk("resp_data", 64'(resp_data), 64'(e.data));
                chk("resp_flags", 64'(resp_flags), 64'(e.flags));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_resp();
    endtask

    // Called in an IDLE cycle with requests set up; done comes in WAIT cycle n_wait.
    task automatic grant_and_run(input logic [1:0] exp_gnt, input int n_wait,
                                 input logic [31:0] outv, input logic [7:0] fl, input bit drop);
        int r0;
        #1;
        chk("gnt", 64'(req_ready), 64'(exp_gnt));
        push(exp_gnt, outv, {1'b0, fl}, 1'b1);
        r0 = resp_seen;
        tick();
        if (drop) req_valid = 2'b00;
        chk("issue_en", 64'(fpu_enable), 64'd1);
        repeat (n_wait) tick();
        fpu_done  = 1'b1;
        fpu_out   = outv;
        fpu_flags = fl;
        tick();
        fpu_done = 1'b0;
        chk("resp_seen", 64'(resp_seen), 64'(r0 + 1));
        tick();
    endtask

    initial begin
        int cyc;
        rst       = 1'b1;
        test_mode = 1'b0;
        req_valid = 2'b00;
        req_op    = '0;
        req_a1    = '0;
        req_a2    = '0;
        req_a3    = '0;
        req_data  = '0;
        fpu_done  = 1'b0;
        fpu_out   = '0;
        fpu_flags = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_en", 64'(fpu_enable), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_flags", 64'(resp_flags), 64'd0);
        rst = 1'b0;
        tick();

        // load on requester 0
        req_valid   = 2'b01;
        req_op[0]   = 3'b100;
        req_a1[0]   = 5'd3;
        req_data[0] = 32'h43A0CCCD;
        #1;
        chk("ld_ready", 64'(req_ready), 64'b01);
        push(2'b01, 32'h0, 9'h000, 1'b0);
        tick();
        req_valid = 2'b00;
        chk("ld_c1_en", 64'(fpu_enable), 64'd1);
        chk("ld_c1_ld", 64'(fpu_ld), 64'd0);
        chk("ld_addr1", 64'(fpu_addr1), 64'd3);
        chk("ld_inp", 64'(fpu_inp), 64'h43A0CCCD);
        chk("ld_busy", 64'(busy), 64'd1);
        tick();
        chk("ld_c2_en", 64'(fpu_enable), 64'd1);
        chk("ld_c2_ld", 64'(fpu_ld), 64'd1);
        tick();
        chk("ld_c3_resp", 64'(resp_valid), 64'b01);
        chk("ld_c3_en", 64'(fpu_enable), 64'd0);
        chk("ld_c3_ld", 64'(fpu_ld), 64'd0);
        tick();
        chk("ld_idle_busy", 64'(busy), 64'd0);

        // add on requester 0, done in the 4th WAIT cycle
        req_valid = 2'b01;
        req_op[0] = 3'b000;
        req_a1[0] = 5'd1;
        req_a2[0] = 5'd2;
        req_a3[0] = 5'd4;
        #1;
        chk("add_ready", 64'(req_ready), 64'b01);
        push(2'b01, 32'h40200000, 9'h008, 1'b1);
        tick();
        req_valid = 2'b00;
        chk("add_issue_en", 64'(fpu_enable), 64'd1);
        chk("add_opcode", 64'(fpu_opcode), 64'd0);
        chk("add_addr3", 64'(fpu_addr3), 64'd4);
        repeat (4) tick();
        chk("add_wait_en", 64'(fpu_enable), 64'd1);
        chk("add_wait_noresp", 64'(resp_valid), 64'd0);
        fpu_done  = 1'b1;
        fpu_out   = 32'h40200000;
        fpu_flags = 8'h08;
        tick();
        fpu_done = 1'b0;
        chk("add_resp_next", 64'(resp_valid), 64'b01);
        chk("add_tmo_flag", 64'(resp_flags[8]), 64'd0);
        chk("add_resp_en", 64'(fpu_enable), 64'd0);
        tick();

        // requester 1 alone, moves the pointer back to requester 0
        req_valid = 2'b10;
        req_op[1] = 3'b010;
        grant_and_run(2'b10, 1, 32'h41000000, 8'h00, 1'b1);

        // both continuously valid: 0,1,0,1
        req_valid = 2'b11;
        req_op[0] = 3'b000;
        req_op[1] = 3'b010;
        for (int n = 0; n < 4; n++) begin
            grant_and_run((n % 2 == 0) ? 2'b01 : 2'b10, 2, 32'h3F800000 + 32'(n),
                          8'(1 << n), (n == 3));
        end

        // divide with no done: timeout
        req_valid = 2'b10;
        req_op[1] = 3'b011;
        fpu_out   = 32'hDEADBEEF;
        #1;
        chk("div_ready", 64'(req_ready), 64'b10);
        push(2'b10, 32'h0, 9'h100, 1'b1);
        tick();
        req_valid = 2'b00;
        cyc = 1;
        while (resp_valid === 2'b00 && cyc < 30) begin
            tick();
            cyc++;
        end
        chk("div_resp", 64'(resp_valid), 64'b10);
        chk("div_latency_min", 64'(cyc >= int'(TMO) + 1), 64'd1);
        chk("div_resp_en", 64'(fpu_enable), 64'd0);
        tick();
        chk("div_busy_low", 64'(busy), 64'd0);

        // test_mode blocks grants
        test_mode = 1'b1;
        req_valid = 2'b11;
        req_op[0] = 3'b001;
        req_op[1] = 3'b000;
        #1;
        chk("tm_ready", 64'(req_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("tm_en", 64'(fpu_enable), 64'd0);
            chk("tm_ready_hold", 64'(req_ready), 64'd0);
        end
        test_mode = 1'b0;
        #1;
        chk("tm_release_gnt", 64'(req_ready), 64'b01);
        push(2'b01, 32'h12345678, 9'h001, 1'b1);
        tick();
        req_valid = 2'b10;
        tick();
        test_mode = 1'b1;
        fpu_done  = 1'b1;
        fpu_out   = 32'h12345678;
        fpu_flags = 8'h01;
        tick();
        fpu_done = 1'b0;
        chk("tm_mid_resp", 64'(resp_valid), 64'b01);
        tick();
        #1;
        chk("tm_no_gnt", 64'(req_ready), 64'd0);
        tick();
        chk("tm_no_busy", 64'(busy), 64'd0);
        req_valid = 2'b00;
        test_mode = 1'b0;
        tick();

        // reset during WAIT discards the command
        req_valid = 2'b10;
        req_op[1] = 3'b001;
        req_a1[1] = 5'd7;
        #1;
        chk("rw_ready", 64'(req_ready), 64'b10);
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        chk("rw_in_wait", 64'(fpu_enable), 64'd1);
        #2;
        rst       = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("rw_busy", 64'(busy), 64'd0);
        chk("rw_en", 64'(fpu_enable), 64'd0);
        chk("rw_opcode", 64'(fpu_opcode), 64'd0);
        chk("rw_addr1", 64'(fpu_addr1), 64'd0);
        chk("rw_resp_data", 64'(resp_data), 64'd0);
        chk("rw_resp_valid", 64'(resp_valid), 64'd0);
        chk("rw_ready", 64'(req_ready), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        req_op[0] = 3'b010;
        grant_and_run(2'b01, 1, 32'h40400000, 8'h02, 1'b1);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("resp_total", 64'(resp_seen), 64'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
